risc8_fetch_seq: RTL
====================

// Module: risc8_fetch_seq
// PURPOSE
//  Instruction fetch sequencer for the risc8 core. Reads variable-length instructions from
//  byte-wide program memory: one opcode byte plus 0-3 immediate bytes, with the count given
//  by the decoder's isize for that opcode. Presents each complete instruction to decode/execute
//  over a valid/ready handshake. Sits between program memory and controller8/datapath;
//  accepts redirects (jump, branch, call, ret, reti) from execute.
// PARAMETERS
//  PC_W     16   program counter / program memory address width
//  RST_VEC  0    PC value loaded on reset
// PORTS
//  clk          in   1     core clock, all state on rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  pm_addr      out  PC_W  program memory byte address
//  pm_rd        out  1     read strobe; pm_data valid exactly 1 cycle later
//  pm_data      in   8     program memory read data
//  dec_opcode   out  8     opcode byte driven to controller instr input for size lookup
//  dec_isize    in   2     immediate byte count for dec_opcode, combinational return
//  redirect     in   1     execute requests PC change (1-cycle pulse)
//  redirect_pc  in   PC_W  new PC when redirect=1
//  out_valid    out  1     out_* hold a complete instruction
//  out_ready    in   1     consumer accepts; transfer when out_valid & out_ready
//  out_instr    out  8     opcode byte
//  out_imm      out  24    immediates; first byte after opcode in [7:0]; unused bytes 0
//  out_pc       out  PC_W  address of the opcode byte
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RST_VEC, state=S_OP, out_valid=0, out_instr=0, out_imm=0,
//   out_pc=0, cnt=idx=0. pm_rd is combinational from state and is 0 while rst_n=0;
//   pm_rd=1 in the first cycle after release.
//  FSM:
//  - S_OP:  pm_rd=1, pm_addr=pc; opc_pc<=pc; pc<=pc+1; go to S_OPW.
//  - S_OPW: dec_opcode=pm_data (combinational); out_instr<=pm_data; cnt<=dec_isize;
//           out_imm<=0; idx<=0.
//           If dec_isize==0, go to S_OUT.
//           Else pm_rd=1, pm_addr=pc, pc<=pc+1, go to S_IMM.
//  - S_IMM: out_imm[8*idx+:8]<=pm_data; idx<=idx+1.
//           If idx+1==cnt, go to S_OUT.
//           Else pm_rd=1, pm_addr=pc, pc<=pc+1, stay.
//  - S_OUT: out_valid=1, out_pc=opc_pc, pm_rd=0. On out_ready go to S_OP. No prefetch overlap.
//  - dec_opcode holds out_instr in all states other than S_OPW.
//  Latency after reset or redirect: out_valid rises 2+isize cycles after S_OP entry.
//   Best-case throughput is one instruction per 3+isize cycles.
//  out_instr, out_imm and out_pc are stable while out_valid=1 and out_ready=0.
//  PC arithmetic is modulo 2^PC_W: 0xFFFF+1 wraps to 0x0000, including mid-instruction.
//  Redirect has priority in every state:
//  - pc<=redirect_pc, state<=S_OP, out_valid<=0.
//  - Partial opcode/immediates are discarded.
//  - pm_rd is forced 0 in the redirect cycle.
//  - Read data already in flight is ignored.
//  Redirect in S_OUT together with out_ready: the transfer completes (consumer took it),
//   then the redirect applies. Redirect in S_OUT without out_ready: the held instruction
//   is dropped.
//  Redirect held high for several cycles: the last redirect_pc wins; fetch starts the cycle
//   after redirect drops.
//  Undefined opcodes get isize from the decoder default (0); the sequencer does no checking.
// TESTING
//  1. Release reset, mem[0]=0x05 with isize 0:
//     pm_rd at cycle 1 addr 0; out_valid cycle 3; instr 0x05, imm 0, pc 0.
//  2. mem[1]=0x80 with isize 3, mem[2..4]=AA,BB,CC:
//     out_imm=0xCCBBAA, out_pc=1; next pm_addr=5.
//  3. out_ready held 0 for 5 cycles in S_OUT:
//     outputs constant, pm_rd=0 throughout; accepted on cycle 6, then fetch at next address.
//  4. redirect=1 with redirect_pc=0x0100 during 2nd immediate of an isize-3 instruction:
//     no out_valid for it; next pm_addr=0x0100.
//  5. pc=0xFFFF, opcode with isize 1:
//     immediate read from 0x0000; out_pc=0xFFFF; next fetch at 0x0001.
//  6. rst_n low mid S_IMM:
//     out_valid/out_* go 0 asynchronously; after release fetch restarts at RST_VEC.

Source files
------------

// File: rtl/risc8_fetch_seq.sv
// risc8 instruction fetch sequencer.
// Fetches one opcode byte and 0-3 immediate bytes from byte-wide program memory. The memory
// returns read data one cycle after the strobe. Each complete instruction is presented on a
// valid/ready handshake. A redirect from execute restarts fetch at a new PC.
module risc8_fetch_seq #(
    parameter int unsigned     PC_W    = 16,
    parameter logic [PC_W-1:0] RST_VEC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    // program memory
    output logic [PC_W-1:0] pm_addr,
    output logic            pm_rd,
    input  logic [7:0]      pm_data,
    // decoder size lookup
    output logic [7:0]      dec_opcode,
    input  logic [1:0]      dec_isize,
    // redirect from execute
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    // instruction output
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_instr,
    output logic [23:0]     out_imm,
    output logic [PC_W-1:0] out_pc
);

    typedef enum logic [1:0] {StOp, StOpw, StImm, StOut} state_e;

    localparam logic [PC_W-1:0] PcOne = PC_W'(1);

    state_e          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] opc_pc;
    logic [1:0]      cnt;
    logic [1:0]      idx;
    logic            imm_last;

    assign imm_last = (idx + 2'd1) == cnt;
    assign pm_addr  = pc;

    // Opcode goes straight from memory to the decoder while it is arriving; otherwise hold it.
    assign dec_opcode = (state == StOpw) ? pm_data : out_instr;

    // Read strobe: issued whenever the next state consumes a new byte; suppressed by redirect
    // and while reset is asserted.
    always_comb begin
        pm_rd = 1'b0;
        unique case (state)
            StOp:  pm_rd = 1'b1;
            StOpw: pm_rd = (dec_isize != 2'd0);
            StImm: pm_rd = !imm_last;
            StOut: pm_rd = 1'b0;
        endcase
        if (redirect || !rst_n) begin
            pm_rd = 1'b0;
        end
    end

    // Fetch FSM with registered instruction outputs; redirect overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StOp;
            pc        <= RST_VEC;
            opc_pc    <= '0;
            cnt       <= 2'd0;
            idx       <= 2'd0;
            out_valid <= 1'b0;
            out_instr <= 8'h00;
            out_imm   <= 24'h0;
            out_pc    <= '0;
        end else if (redirect) begin
            // In-flight read data is simply never consumed once we are back in StOp.
            pc        <= redirect_pc;
            state     <= StOp;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                StOp: begin
                    opc_pc <= pc;
                    pc     <= pc + PcOne;
                    state  <= StOpw;
                end
                StOpw: begin
                    out_instr <= pm_data;
                    cnt       <= dec_isize;
                    out_imm   <= 24'h0;
                    idx       <= 2'd0;
                    if (dec_isize == 2'd0) begin
                        out_valid <= 1'b1;
                        out_pc    <= opc_pc;
                        state     <= StOut;
                    end else begin
                        pc    <= pc + PcOne;
                        state <= StImm;
                    end
                end
                StImm: begin
                    unique case (idx)
                        2'd0:    out_imm[7:0]   <= pm_data;
                        2'd1:    out_imm[15:8]  <= pm_data;
                        default: out_imm[23:16] <= pm_data;
                    endcase
                    idx <= idx + 2'd1;
                    if (imm_last) begin
                        out_valid <= 1'b1;
                        out_pc    <= opc_pc;
                        state     <= StOut;
                    end else begin
                        pc <= pc + PcOne;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StOp;
                    end
                end
            endcase
        end
    end

endmodule
